// File: rtl/nasti_bram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nasti_bram_ctrl
// Purpose  : NASTI (AXI4) slave that serves INCR bursts of any length from an
//            inferred single-port BRAM. Only one transaction is open at a time.
//            When reads and writes are requested in the same cycle, the two
//            directions take turns.
//            Write bursts whose beat count differs from aw_len+1 get SLVERR.
//            Optional address range check: define NASTI_BRAM_RANGE_CHK_EN.
// Ports    : clk, rst (async, active high)
//            AW: i_aw_valid/o_aw_ready, i_aw_id, i_aw_addr, i_aw_len
//            W : i_w_valid/o_w_ready, i_w_data, i_w_strb, i_w_last
//            B : o_b_valid/i_b_ready, o_b_id, o_b_resp
//            AR: i_ar_valid/o_ar_ready, i_ar_id, i_ar_addr, i_ar_len
//            R : o_r_valid/i_r_ready, o_r_id, o_r_data, o_r_resp, o_r_last
// Revision : 1.0 - initial release
// ============================================================================
module nasti_bram_ctrl #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_DEPTH  = 8192
) (
  input  logic                    clk,
  input  logic                    rst,
  // write address
  input  logic                    i_aw_valid,
  output logic                    o_aw_ready,
  input  logic [ID_WIDTH-1:0]     i_aw_id,
  input  logic [ADDR_WIDTH-1:0]   i_aw_addr,
  input  logic [7:0]              i_aw_len,
  // write data
  input  logic                    i_w_valid,
  output logic                    o_w_ready,
  input  logic [DATA_WIDTH-1:0]   i_w_data,
  input  logic [DATA_WIDTH/8-1:0] i_w_strb,
  input  logic                    i_w_last,
  // write response
  output logic                    o_b_valid,
  input  logic                    i_b_ready,
  output logic [ID_WIDTH-1:0]     o_b_id,
  output logic [1:0]              o_b_resp,
  // read address
  input  logic                    i_ar_valid,
  output logic                    o_ar_ready,
  input  logic [ID_WIDTH-1:0]     i_ar_id,
  input  logic [ADDR_WIDTH-1:0]   i_ar_addr,
  input  logic [7:0]              i_ar_len,
  // read data
  output logic                    o_r_valid,
  input  logic                    i_r_ready,
  output logic [ID_WIDTH-1:0]     o_r_id,
  output logic [DATA_WIDTH-1:0]   o_r_data,
  output logic [1:0]              o_r_resp,
  output logic                    o_r_last
);

  localparam int c_STRB_W = DATA_WIDTH / 8;
  localparam int c_OFF    = $clog2(c_STRB_W);
  localparam int c_IDX_W  = $clog2(MEM_DEPTH);
  localparam int c_HI_W   = ADDR_WIDTH - c_OFF - c_IDX_W;

`ifdef NASTI_BRAM_RANGE_CHK_EN
  localparam bit c_RANGE_CHK = 1'b1;
`else
  localparam bit c_RANGE_CHK = 1'b0;
`endif

  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;
  localparam logic [1:0] c_RESP_DECERR = 2'b11;
  localparam logic [c_IDX_W-1:0] c_IDX_TOP = {c_IDX_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR_DATA = 2'd1,
    S_WR_RESP = 2'd2,
    S_RD      = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_WIDTH-1:0] r_mem [0:MEM_DEPTH-1];

  // arbitration: 0 = read wins a tie, 1 = write wins a tie
  logic                  r_pri_wr;

  // write context
  logic [c_IDX_W-1:0]    r_wr_idx;
  logic [7:0]            r_wr_len;
  logic [7:0]            r_wr_cnt;
  logic                  r_wr_err;   // sticky beat-count mismatch
  logic                  r_wr_oor;   // current beat is outside the RAM
  logic                  r_wr_dec;   // some earlier beat was outside the RAM
  logic [ID_WIDTH-1:0]   r_b_id;
  logic [1:0]            r_b_resp;

  // read context
  logic [c_IDX_W-1:0]    r_rd_idx;
  logic [7:0]            r_rd_len;
  logic [7:0]            r_rd_cnt;   // beats issued to the RAM so far
  logic                  r_rd_more;  // beats still to be issued
  logic                  r_rd_oor;
  logic [ID_WIDTH-1:0]   r_r_id;
  logic [1:0]            r_r_resp;
  logic [DATA_WIDTH-1:0] r_r_data;
  logic                  r_r_valid;
  logic                  r_r_last;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [c_IDX_W-1:0] w_aw_idx;
  logic [c_IDX_W-1:0] w_ar_idx;
  logic               w_aw_oor;
  logic               w_ar_oor;
  logic [c_IDX_W:0]   w_ar_end;
  logic               w_ar_cross;
  logic               w_unused_addr;

  assign w_aw_idx   = i_aw_addr[c_OFF +: c_IDX_W];
  assign w_ar_idx   = i_ar_addr[c_OFF +: c_IDX_W];
  assign w_aw_oor   = c_RANGE_CHK && (|i_aw_addr[ADDR_WIDTH-1 -: c_HI_W]);
  assign w_ar_oor   = c_RANGE_CHK && (|i_ar_addr[ADDR_WIDTH-1 -: c_HI_W]);
  // the read burst length is known up front, so a burst running off the top
  // word is flagged at address time and the response stays constant
  assign w_ar_end   = {1'b0, w_ar_idx} + {{(c_IDX_W-7){1'b0}}, i_ar_len};
  assign w_ar_cross = c_RANGE_CHK && w_ar_end[c_IDX_W];
  // byte offset within a beat is meaningless for full-width bursts
  assign w_unused_addr = ^{i_aw_addr[c_OFF-1:0], i_ar_addr[c_OFF-1:0]};

  // ---------------------------------------------------------------------------
  // Arbitration and FSM
  // ---------------------------------------------------------------------------
  logic w_grant_rd;
  logic w_grant_wr;
  logic w_w_hs;
  logic w_rd_issue;
  logic w_mem_we;
  logic w_wr_cnt_bad;

  // readies must not leak through while reset is held
  assign w_grant_rd = !rst && i_ar_valid && (!i_aw_valid || !r_pri_wr);
  assign w_grant_wr = !rst && i_aw_valid && (!i_ar_valid || r_pri_wr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_aw_ready  = 1'b0;
    o_ar_ready  = 1'b0;
    o_w_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_rd) begin
          o_ar_ready  = 1'b1;
          w_state_nxt = S_RD;
        end else if (w_grant_wr) begin
          o_aw_ready  = 1'b1;
          w_state_nxt = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        o_w_ready = 1'b1;
        if (i_w_valid && i_w_last) begin
          w_state_nxt = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (i_b_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD: begin
        if (r_r_valid && i_r_ready && r_r_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_w_hs       = o_w_ready && i_w_valid;
  assign w_mem_we     = w_w_hs && !r_wr_oor;
  // a beat is wrong if w_last disagrees with "this is beat aw_len"
  assign w_wr_cnt_bad = i_w_last != (r_wr_cnt == r_wr_len);
  // one read in flight at most: issue only if the output register frees up
  assign w_rd_issue   = (r_state == S_RD) && r_rd_more && (!r_r_valid || i_r_ready);

  // ---------------------------------------------------------------------------
  // RAM write port (no reset so the array maps onto block RAM)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < c_STRB_W; b++) begin
        if (i_w_strb[b]) begin
          r_mem[r_wr_idx][b*8 +: 8] <= i_w_data[b*8 +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pri_wr  <= 1'b0;
      r_wr_idx  <= '0;
      r_wr_len  <= '0;
      r_wr_cnt  <= '0;
      r_wr_err  <= 1'b0;
      r_wr_oor  <= 1'b0;
      r_wr_dec  <= 1'b0;
      r_b_id    <= '0;
      r_b_resp  <= c_RESP_OKAY;
      r_rd_idx  <= '0;
      r_rd_len  <= '0;
      r_rd_cnt  <= '0;
      r_rd_more <= 1'b0;
      r_rd_oor  <= 1'b0;
      r_r_id    <= '0;
      r_r_resp  <= c_RESP_OKAY;
      r_r_data  <= '0;
      r_r_valid <= 1'b0;
      r_r_last  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && i_aw_valid && i_ar_valid) begin
        r_pri_wr <= ~r_pri_wr;
      end

      // write address accept
      if (o_aw_ready) begin
        r_wr_idx <= w_aw_idx;
        r_wr_len <= i_aw_len;
        r_wr_cnt <= '0;
        r_wr_err <= 1'b0;
        r_wr_oor <= w_aw_oor;
        r_wr_dec <= 1'b0;
        r_b_id   <= i_aw_id;
      end

      // write beat
      if (w_w_hs) begin
        r_wr_idx <= r_wr_idx + c_IDX_W'(1);
        r_wr_cnt <= r_wr_cnt + 8'd1;
        r_wr_dec <= r_wr_dec | r_wr_oor;
        if (w_wr_cnt_bad) begin
          r_wr_err <= 1'b1;
        end
        // stepping past the top word leaves the RAM instead of wrapping
        if (c_RANGE_CHK && r_wr_idx == c_IDX_TOP) begin
          r_wr_oor <= 1'b1;
        end
        if (i_w_last) begin
          if (r_wr_dec || r_wr_oor) begin
            r_b_resp <= c_RESP_DECERR;
          end else if (r_wr_err || w_wr_cnt_bad) begin
            r_b_resp <= c_RESP_SLVERR;
          end else begin
            r_b_resp <= c_RESP_OKAY;
          end
        end
      end

      // read address accept
      if (o_ar_ready) begin
        r_rd_idx  <= w_ar_idx;
        r_rd_len  <= i_ar_len;
        r_rd_cnt  <= '0;
        r_rd_more <= 1'b1;
        r_rd_oor  <= w_ar_oor;
        r_r_id    <= i_ar_id;
        r_r_resp  <= (w_ar_oor || w_ar_cross) ? c_RESP_DECERR : c_RESP_OKAY;
      end

      // read beat: r_r_data doubles as the RAM output register
      if (w_rd_issue) begin
        r_r_data  <= r_rd_oor ? '0 : r_mem[r_rd_idx];
        r_r_valid <= 1'b1;
        r_r_last  <= (r_rd_cnt == r_rd_len);
        r_rd_more <= (r_rd_cnt != r_rd_len);
        r_rd_cnt  <= r_rd_cnt + 8'd1;
        r_rd_idx  <= r_rd_idx + c_IDX_W'(1);
        if (c_RANGE_CHK && r_rd_idx == c_IDX_TOP) begin
          r_rd_oor <= 1'b1;
        end
      end else if (r_r_valid && i_r_ready) begin
        r_r_valid <= 1'b0;
        r_r_last  <= 1'b0;
      end
    end
  end

  assign o_b_valid = (r_state == S_WR_RESP);
  assign o_b_id    = r_b_id;
  assign o_b_resp  = r_b_resp;
  assign o_r_valid = r_r_valid;
  assign o_r_id    = r_r_id;
  assign o_r_data  = r_r_data;
  assign o_r_resp  = r_r_resp;
  assign o_r_last  = r_r_last;

endmodule
`default_nettype wire

// File: tb/tb_nasti_bram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nasti_bram_ctrl
// Purpose  : Self-checking bench for nasti_bram_ctrl (64-bit data, 8192 words).
//            Single-beat vectors come from a table; bursts, arbitration and
//            reset-during-read are driven as hand-written sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nasti_bram_ctrl;

  localparam int IDW = 4;
  localparam int AW  = 32;
  localparam int DW  = 64;

`ifdef NASTI_BRAM_RANGE_CHK_EN
  localparam bit c_CHK = 1'b1;
`else
  localparam bit c_CHK = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic            i_aw_valid, o_aw_ready;
  logic [IDW-1:0]  i_aw_id;
  logic [AW-1:0]   i_aw_addr;
  logic [7:0]      i_aw_len;
  logic            i_w_valid, o_w_ready;
  logic [DW-1:0]   i_w_data;
  logic [DW/8-1:0] i_w_strb;
  logic            i_w_last;
  logic            o_b_valid, i_b_ready;
  logic [IDW-1:0]  o_b_id;
  logic [1:0]      o_b_resp;
  logic            i_ar_valid, o_ar_ready;
  logic [IDW-1:0]  i_ar_id;
  logic [AW-1:0]   i_ar_addr;
  logic [7:0]      i_ar_len;
  logic            o_r_valid, i_r_ready;
  logic [IDW-1:0]  o_r_id;
  logic [DW-1:0]   o_r_data;
  logic [1:0]      o_r_resp;
  logic            o_r_last;

  nasti_bram_ctrl #(
    .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(8192)
  ) u_dut (
    .clk(clk), .rst(rst),
    .i_aw_valid(i_aw_valid), .o_aw_ready(o_aw_ready), .i_aw_id(i_aw_id),
    .i_aw_addr(i_aw_addr), .i_aw_len(i_aw_len),
    .i_w_valid(i_w_valid), .o_w_ready(o_w_ready), .i_w_data(i_w_data),
    .i_w_strb(i_w_strb), .i_w_last(i_w_last),
    .o_b_valid(o_b_valid), .i_b_ready(i_b_ready), .o_b_id(o_b_id), .o_b_resp(o_b_resp),
    .i_ar_valid(i_ar_valid), .o_ar_ready(o_ar_ready), .i_ar_id(i_ar_id),
    .i_ar_addr(i_ar_addr), .i_ar_len(i_ar_len),
    .o_r_valid(o_r_valid), .i_r_ready(i_r_ready), .o_r_id(o_r_id),
    .o_r_data(o_r_data), .o_r_resp(o_r_resp), .o_r_last(o_r_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0]  wbuf [0:255];
  logic [DW-1:0]  rdat [0:255];
  logic           rlst [0:255];
  logic [1:0]     rrsp [0:255];
  logic [IDW-1:0] rids [0:255];
  int             nrx;
  int             first_valid;

  typedef struct {
    bit            wr;
    logic [IDW-1:0] id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [7:0]    strb;
    logic [DW-1:0] exp_data;
    logic [1:0]    exp_resp;
  } vec_t;

  vec_t tbl [0:11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout waiting for handshake", name);
  endtask

  task automatic aw_phase(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len);
    int to;
    i_aw_valid = 1'b1; i_aw_id = id; i_aw_addr = addr; i_aw_len = len;
    to = 0;
    #1;
    while (!o_aw_ready && to < 100) begin @(negedge clk); #1; to++; end
    if (!o_aw_ready) timeout("aw");
    @(negedge clk);
    i_aw_valid = 1'b0;
  endtask

  task automatic w_beats(input int n, input logic [7:0] strb);
    int to;
    for (int i = 0; i < n; i++) begin
      i_w_valid = 1'b1; i_w_data = wbuf[i]; i_w_strb = strb; i_w_last = (i == n - 1);
      to = 0;
      #1;
      while (!o_w_ready && to < 100) begin @(negedge clk); #1; to++; end
      if (!o_w_ready) timeout("w");
      @(negedge clk);
    end
    i_w_valid = 1'b0; i_w_last = 1'b0;
  endtask

  task automatic b_phase(output logic [IDW-1:0] bid, output logic [1:0] bresp);
    int to;
    i_b_ready = 1'b1;
    to = 0;
    #1;
    while (!o_b_valid && to < 100) begin @(negedge clk); #1; to++; end
    if (!o_b_valid) timeout("b");
    bid = o_b_id; bresp = o_b_resp;
    @(negedge clk);
    i_b_ready = 1'b0;
  endtask

  task automatic axi_write(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                           input int n, input logic [7:0] strb,
                           output logic [IDW-1:0] bid, output logic [1:0] bresp);
    aw_phase(id, addr, len);
    w_beats(n, strb);
    b_phase(bid, bresp);
  endtask

  task automatic ar_phase(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len);
    int to;
    i_ar_valid = 1'b1; i_ar_id = id; i_ar_addr = addr; i_ar_len = len;
    to = 0;
    #1;
    while (!o_ar_ready && to < 100) begin @(negedge clk); #1; to++; end
    if (!o_ar_ready) timeout("ar");
    @(negedge clk);
    i_ar_valid = 1'b0;
  endtask

  // Collects beats until r_last; with toggle, r_ready alternates 0/1 and any
  // stalled beat must hold its data into the next cycle.
  task automatic r_collect(input bit toggle);
    int            it;
    bit            done;
    bit            stalled;
    logic [DW-1:0] held;
    it = 0; done = 1'b0; stalled = 1'b0; held = '0;
    nrx = 0; first_valid = -1;
    while (!done && it < 2000) begin
      i_r_ready = toggle ? (it % 2 == 1) : 1'b1;
      #1;
      if (o_r_valid) begin
        if (first_valid < 0) first_valid = it;
        if (stalled) chk("r_stall_hold", o_r_data, held);
        if (i_r_ready) begin
          rdat[nrx] = o_r_data; rlst[nrx] = o_r_last; rrsp[nrx] = o_r_resp; rids[nrx] = o_r_id;
          nrx++;
          stalled = 1'b0;
          if (o_r_last || nrx == 256) done = 1'b1;
        end else begin
          stalled = 1'b1;
          held    = o_r_data;
        end
      end
      @(negedge clk);
      it++;
    end
    i_r_ready = 1'b0;
    if (!done) timeout("r");
  endtask

  task automatic axi_read(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input bit toggle);
    ar_phase(id, addr, len);
    r_collect(toggle);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IDW-1:0] bid;
    logic [1:0]     bresp;
    int             nlast;
    int             to;

    // table: single-beat writes and reads with hand-computed results
    tbl[0]  = '{1'b1, 4'd3,  32'h10,    64'h1122334455667788, 8'hFF, 64'h0, 2'b00};
    tbl[1]  = '{1'b0, 4'd5,  32'h10,    64'h0, 8'h0, 64'h1122334455667788, 2'b00};
    tbl[2]  = '{1'b1, 4'd1,  32'h10,    64'hAAAAAAAABBBBBBBB, 8'h0F, 64'h0, 2'b00};
    tbl[3]  = '{1'b0, 4'd2,  32'h10,    64'h0, 8'h0, 64'h11223344BBBBBBBB, 2'b00};
    tbl[4]  = '{1'b1, 4'd6,  32'h00,    64'h0123456789ABCDEF, 8'hFF, 64'h0, 2'b00};
    tbl[5]  = '{1'b1, 4'd7,  32'h08,    64'hFFEEDDCCBBAA9988, 8'hFF, 64'h0, 2'b00};
    tbl[6]  = '{1'b1, 4'd8,  32'h08,    64'h0, 8'h81, 64'h0, 2'b00};
    tbl[7]  = '{1'b0, 4'd9,  32'h08,    64'h0, 8'h0, 64'h00EEDDCCBBAA9900, 2'b00};
    tbl[8]  = '{1'b0, 4'd10, 32'h00,    64'h0, 8'h0, 64'h0123456789ABCDEF, 2'b00};
    // first address past the RAM: decode error with the range check, alias otherwise
    tbl[9]  = '{1'b1, 4'd11, 32'h10000, 64'h5555555555555555, 8'hFF, 64'h0,
                c_CHK ? 2'b11 : 2'b00};
    tbl[10] = '{1'b0, 4'd12, 32'h00,    64'h0, 8'h0,
                c_CHK ? 64'h0123456789ABCDEF : 64'h5555555555555555, 2'b00};
    tbl[11] = '{1'b0, 4'd13, 32'h10000, 64'h0, 8'h0,
                c_CHK ? 64'h0 : 64'h5555555555555555, c_CHK ? 2'b11 : 2'b00};

    rst = 1'b1;
    i_aw_valid = 1'b1; i_aw_id = '0; i_aw_addr = '0; i_aw_len = '0;
    i_w_valid = 1'b0; i_w_data = '0; i_w_strb = '0; i_w_last = 1'b0;
    i_b_ready = 1'b0;
    i_ar_valid = 1'b1; i_ar_id = '0; i_ar_addr = '0; i_ar_len = '0;
    i_r_ready = 1'b0;

    // ---- reset state (requests pending must not be acknowledged) ----
    repeat (3) @(negedge clk);
    #1;
    chk("rst_aw_ready", o_aw_ready, 0);
    chk("rst_ar_ready", o_ar_ready, 0);
    chk("rst_w_ready",  o_w_ready,  0);
    chk("rst_b_valid",  o_b_valid,  0);
    chk("rst_r_valid",  o_r_valid,  0);
    chk("rst_r_data",   o_r_data,   0);
    chk("rst_r_last",   o_r_last,   0);
    chk("rst_ids",      {o_b_id, o_r_id}, 0);
    chk("rst_resps",    {o_b_resp, o_r_resp}, 0);
    @(negedge clk);
    i_aw_valid = 1'b0; i_ar_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // ---- table-driven single beats ----
    for (int v = 0; v < 12; v++) begin
      if (tbl[v].wr) begin
        wbuf[0] = tbl[v].data;
        axi_write(tbl[v].id, tbl[v].addr, 8'd0, 1, tbl[v].strb, bid, bresp);
        chk($sformatf("vec%0d_b_id", v), bid, tbl[v].id);
        chk($sformatf("vec%0d_b_resp", v), bresp, tbl[v].exp_resp);
      end else begin
        axi_read(tbl[v].id, tbl[v].addr, 8'd0, 1'b0);
        chk($sformatf("vec%0d_beats", v), nrx, 1);
        chk($sformatf("vec%0d_latency", v), first_valid, 1);
        chk($sformatf("vec%0d_r_data", v), rdat[0], tbl[v].exp_data);
        chk($sformatf("vec%0d_r_resp", v), rrsp[0], tbl[v].exp_resp);
        chk($sformatf("vec%0d_r_id", v), rids[0], tbl[v].id);
        chk($sformatf("vec%0d_r_last", v), rlst[0], 1);
      end
    end

    // ---- 8-beat burst, read back with r_ready toggling ----
    for (int i = 0; i < 8; i++) wbuf[i] = 64'(i);
    axi_write(4'd4, 32'h100, 8'd7, 8, 8'hFF, bid, bresp);
    chk("burst8_b_resp", bresp, 2'b00);
    chk("burst8_b_id", bid, 4'd4);
    axi_read(4'd6, 32'h100, 8'd7, 1'b1);
    chk("burst8_beats", nrx, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("burst8_data%0d", i), rdat[i], 64'(i));
      chk($sformatf("burst8_last%0d", i), rlst[i], (i == 7));
      chk($sformatf("burst8_id%0d", i), {rrsp[i], rids[i]}, {2'b00, 4'd6});
    end

    // ---- 256-beat burst ----
    for (int i = 0; i < 256; i++) wbuf[i] = 64'hC0DE_0000_0000_0000 | 64'(i * 3);
    axi_write(4'd2, 32'h2000, 8'd255, 256, 8'hFF, bid, bresp);
    chk("burst256_b_resp", bresp, 2'b00);
    axi_read(4'd1, 32'h2000, 8'd255, 1'b0);
    chk("burst256_beats", nrx, 256);
    nlast = 0;
    for (int i = 0; i < 256; i++) begin
      chk($sformatf("burst256_data%0d", i), rdat[i], 64'hC0DE_0000_0000_0000 | 64'(i * 3));
      if (rlst[i] === 1'b1) nlast++;
    end
    chk("burst256_last_count", nlast, 1);
    chk("burst256_last_pos", rlst[255], 1);

    // ---- arbitration after reset, then short write burst -> SLVERR ----
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    i_aw_valid = 1'b1; i_aw_id = 4'd9; i_aw_addr = 32'h200; i_aw_len = 8'd3;
    i_ar_valid = 1'b1; i_ar_id = 4'd2; i_ar_addr = 32'h108; i_ar_len = 8'd0;
    #1;
    chk("arb1_ar_ready", o_ar_ready, 1);
    chk("arb1_aw_ready", o_aw_ready, 0);
    @(negedge clk);
    i_ar_valid = 1'b0;
    r_collect(1'b0);
    chk("arb1_r_data", rdat[0], 64'd1);
    i_ar_valid = 1'b1;
    #1;
    chk("arb2_aw_ready", o_aw_ready, 1);
    chk("arb2_ar_ready", o_ar_ready, 0);
    @(negedge clk);
    i_aw_valid = 1'b0; i_ar_valid = 1'b0;
    for (int i = 0; i < 3; i++) wbuf[i] = 64'hB000 + 64'(i);
    w_beats(3, 8'hFF);
    b_phase(bid, bresp);
    chk("short_b_resp", bresp, 2'b10);
    chk("short_b_id", bid, 4'd9);
    axi_read(4'd3, 32'h200, 8'd2, 1'b0);
    chk("short_beats", nrx, 3);
    for (int i = 0; i < 3; i++) chk($sformatf("short_data%0d", i), rdat[i], 64'hB000 + 64'(i));

    // ---- reset in the middle of an 8-beat read ----
    ar_phase(4'd7, 32'h100, 8'd7);
    i_r_ready = 1'b0;
    to = 0;
    #1;
    while (!o_r_valid && to < 100) begin @(negedge clk); #1; to++; end
    if (!o_r_valid) timeout("rst_mid_r");
    @(negedge clk);
    i_ar_valid = 1'b1; i_aw_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("midrst_r_valid",  o_r_valid,  0);
    chk("midrst_r_last",   o_r_last,   0);
    chk("midrst_ar_ready", o_ar_ready, 0);
    chk("midrst_aw_ready", o_aw_ready, 0);
    chk("midrst_w_ready",  o_w_ready,  0);
    chk("midrst_b_valid",  o_b_valid,  0);
    @(negedge clk);
    i_ar_valid = 1'b0; i_aw_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    axi_read(4'd5, 32'h100, 8'd0, 1'b0);
    chk("postrst_beats", nrx, 1);
    chk("postrst_r_data", rdat[0], 64'd0);
    chk("postrst_r_resp", rrsp[0], 2'b00);
    chk("postrst_r_id", rids[0], 4'd5);
    chk("postrst_r_last", rlst[0], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
